// File: rtl/jtkcpu_regs.sv
// Programmer-visible register file of the KONAMI-2 core: operand read mux, ALU writeback,
// TFR/EXG, index auto-increment/decrement and NMI arming on the first write of S.
module jtkcpu_regs #(
   parameter logic [7:0] CC_RST = 8'h50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic [3:0]  rd_sel,
   output logic [15:0] opnd0,
   input  logic        wr_en,
   input  logic [3:0]  wr_sel,
   input  logic [15:0] rslt,
   input  logic        wrh_en,
   input  logic [3:0]  wrh_sel,
   input  logic [15:0] rslt_hi,
   input  logic        cc_we,
   input  logic [7:0]  cc_alu,
   input  logic        tfr,
   input  logic        exg,
   input  logic [7:0]  postbyte,
   input  logic        idx_upd,
   input  logic [1:0]  idx_sel,
   input  logic [1:0]  idx_delta,
   output logic [7:0]  a,
   output logic [7:0]  b,
   output logic [7:0]  dp,
   output logic [7:0]  cc,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic [15:0] u,
   output logic [15:0] s,
   output logic [15:0] d,
   output logic        nmi_arm
);

   localparam int unsigned NCH = 6;

   logic [7:0]  a_q, a_d, b_q, b_d, dp_q, dp_d, cc_q, cc_d;
   logic [15:0] x_q, x_d, y_q, y_d, u_q, u_d, s_q, s_d;
   logic        nmi_q, nmi_d;

   logic [15:0] rd_tab [16];
   logic [3:0]  src, dst, idx_code;
   logic [15:0] idx_inc;

   // Write channels, index 0 has the highest precedence.
   logic        ch_en   [NCH];
   logic [3:0]  ch_code [NCH];
   logic [15:0] ch_val  [NCH];

   assign src = postbyte[7:4];
   assign dst = postbyte[3:0];

   // Register codes as seen on a read: 8-bit registers padded with 8'hFF, unused codes all ones.
   always_comb begin
      for (int i = 0; i < 16; i++) rd_tab[i] = 16'hFFFF;
      rd_tab[0] = {8'hFF, a_q};
      rd_tab[1] = {8'hFF, b_q};
      rd_tab[2] = x_q;
      rd_tab[3] = y_q;
      rd_tab[4] = s_q;
      rd_tab[5] = u_q;
      rd_tab[6] = {a_q, b_q};
      rd_tab[7] = {8'hFF, dp_q};
      rd_tab[8] = {8'hFF, cc_q};
   end

   always_comb begin
      idx_code = 4'd2;
      unique case (idx_sel)
         2'd0: idx_code = 4'd2;
         2'd1: idx_code = 4'd3;
         2'd2: idx_code = 4'd5;
         2'd3: idx_code = 4'd4;
         default: idx_code = 4'd2;
      endcase
      idx_inc = 16'd1;
      unique case (idx_delta)
         2'd0: idx_inc = 16'h0001;
         2'd1: idx_inc = 16'h0002;
         2'd2: idx_inc = 16'hFFFF;
         2'd3: idx_inc = 16'hFFFE;
         default: idx_inc = 16'h0001;
      endcase
   end

   // EXG is split into two writes that both read pre-cycle values; the destination side wins
   // when the two halves overlap (e.g. A with D).
   always_comb begin
      ch_en[0] = exg && (src != dst);  ch_code[0] = dst;       ch_val[0] = rd_tab[src];
      ch_en[1] = exg && (src != dst);  ch_code[1] = src;       ch_val[1] = rd_tab[dst];
      ch_en[2] = tfr;                  ch_code[2] = dst;       ch_val[2] = rd_tab[src];
      ch_en[3] = wr_en;                ch_code[3] = wr_sel;    ch_val[3] = rslt;
      ch_en[4] = wrh_en;               ch_code[4] = wrh_sel;   ch_val[4] = rslt_hi;
      ch_en[5] = idx_upd;              ch_code[5] = idx_code;
      ch_val[5] = rd_tab[idx_code] + idx_inc;
   end

   // Lowest precedence applied first so higher channels overwrite per destination register.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      dp_d  = dp_q;
      cc_d  = cc_we ? cc_alu : cc_q;
      x_d   = x_q;
      y_d   = y_q;
      u_d   = u_q;
      s_d   = s_q;
      nmi_d = nmi_q;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (ch_en[i]) begin
            case (ch_code[i])
               4'd0: a_d  = ch_val[i][7:0];
               4'd1: b_d  = ch_val[i][7:0];
               4'd2: x_d  = ch_val[i];
               4'd3: y_d  = ch_val[i];
               4'd4: begin
                  s_d   = ch_val[i];
                  nmi_d = 1'b1;
               end
               4'd5: u_d  = ch_val[i];
               4'd6: begin
                  a_d = ch_val[i][15:8];
                  b_d = ch_val[i][7:0];
               end
               4'd7: dp_d = ch_val[i][7:0];
               4'd8: cc_d = ch_val[i][7:0];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= 8'd0;
         b_q   <= 8'd0;
         dp_q  <= 8'd0;
         cc_q  <= CC_RST;
         x_q   <= 16'd0;
         y_q   <= 16'd0;
         u_q   <= 16'd0;
         s_q   <= 16'd0;
         nmi_q <= 1'b0;
      end else if (cen) begin
         a_q   <= a_d;
         b_q   <= b_d;
         dp_q  <= dp_d;
         cc_q  <= cc_d;
         x_q   <= x_d;
         y_q   <= y_d;
         u_q   <= u_d;
         s_q   <= s_d;
         nmi_q <= nmi_d;
      end
   end

   assign opnd0   = rd_tab[rd_sel];
   assign a       = a_q;
   assign b       = b_q;
   assign dp      = dp_q;
   assign cc      = cc_q;
   assign x       = x_q;
   assign y       = y_q;
   assign u       = u_q;
   assign s       = s_q;
   assign d       = {a_q, b_q};
   assign nmi_arm = nmi_q;

endmodule

// File: tb/tb_jtkcpu_regs.sv
// Bench for jtkcpu_regs: directed cases plus random strobes checked against a register-level
// model that applies each cycle's writes in rising precedence order.
module tb_jtkcpu_regs;

   logic        clk = 1'b0;
   logic        rst, cen;
   logic [3:0]  rd_sel, wr_sel, wrh_sel;
   logic [15:0] opnd0, rslt, rslt_hi;
   logic        wr_en, wrh_en, cc_we, tfr, exg, idx_upd;
   logic [7:0]  cc_alu, postbyte;
   logic [1:0]  idx_sel, idx_delta;
   logic [7:0]  a, b, dp, cc;
   logic [15:0] x, y, u, s, d;
   logic        nmi_arm;

   int checks = 0;
   int failures = 0;

   // Model state
   logic [7:0]  ma, mb, mdp, mcc;
   logic [15:0] mx, my, mu, ms;
   logic        mnmi;

   always #5 clk = ~clk;

   jtkcpu_regs #(.CC_RST(8'h50)) dut (
      .clk(clk), .rst(rst), .cen(cen), .rd_sel(rd_sel), .opnd0(opnd0),
      .wr_en(wr_en), .wr_sel(wr_sel), .rslt(rslt),
      .wrh_en(wrh_en), .wrh_sel(wrh_sel), .rslt_hi(rslt_hi),
      .cc_we(cc_we), .cc_alu(cc_alu), .tfr(tfr), .exg(exg), .postbyte(postbyte),
      .idx_upd(idx_upd), .idx_sel(idx_sel), .idx_delta(idx_delta),
      .a(a), .b(b), .dp(dp), .cc(cc), .x(x), .y(y), .u(u), .s(s), .d(d),
      .nmi_arm(nmi_arm)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mread(input logic [3:0] c);
      case (c)
         4'd0: return {8'hFF, ma};
         4'd1: return {8'hFF, mb};
         4'd2: return mx;
         4'd3: return my;
         4'd4: return ms;
         4'd5: return mu;
         4'd6: return {ma, mb};
         4'd7: return {8'hFF, mdp};
         4'd8: return {8'hFF, mcc};
         default: return 16'hFFFF;
      endcase
   endfunction

   task automatic mwrite(input logic [3:0] c, input logic [15:0] v);
      case (c)
         4'd0: ma = v[7:0];
         4'd1: mb = v[7:0];
         4'd2: mx = v;
         4'd3: my = v;
         4'd4: begin ms = v; mnmi = 1'b1; end
         4'd5: mu = v;
         4'd6: begin ma = v[15:8]; mb = v[7:0]; end
         4'd7: mdp = v[7:0];
         4'd8: mcc = v[7:0];
         default: ;
      endcase
   endtask

   task automatic mreset();
      ma = 8'd0; mb = 8'd0; mdp = 8'd0; mcc = 8'h50;
      mx = 16'd0; my = 16'd0; mu = 16'd0; ms = 16'd0; mnmi = 1'b0;
   endtask

   // All values are taken from the pre-cycle snapshot, then written lowest precedence first.
   task automatic model_step();
      logic [3:0]  src, dst, ic;
      logic [15:0] vs, vd, vi;
      if (!cen) return;
      src = postbyte[7:4];
      dst = postbyte[3:0];
      vs  = mread(src);
      vd  = mread(dst);
      case (idx_sel)
         2'd0: ic = 4'd2;
         2'd1: ic = 4'd3;
         2'd2: ic = 4'd5;
         default: ic = 4'd4;
      endcase
      case (idx_delta)
         2'd0: vi = mread(ic) + 16'd1;
         2'd1: vi = mread(ic) + 16'd2;
         2'd2: vi = mread(ic) - 16'd1;
         default: vi = mread(ic) - 16'd2;
      endcase
      if (cc_we)   mcc = cc_alu;
      if (idx_upd) mwrite(ic, vi);
      if (wrh_en)  mwrite(wrh_sel, rslt_hi);
      if (wr_en)   mwrite(wr_sel, rslt);
      if (tfr)     mwrite(dst, vs);
      if (exg && src != dst) begin
         mwrite(src, vd);
         mwrite(dst, vs);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".a"},   {8'd0, a},        {8'd0, ma});
      check({tag, ".b"},   {8'd0, b},        {8'd0, mb});
      check({tag, ".dp"},  {8'd0, dp},       {8'd0, mdp});
      check({tag, ".cc"},  {8'd0, cc},       {8'd0, mcc});
      check({tag, ".x"},   x,                mx);
      check({tag, ".y"},   y,                my);
      check({tag, ".u"},   u,                mu);
      check({tag, ".s"},   s,                ms);
      check({tag, ".d"},   d,                {ma, mb});
      check({tag, ".nmi"}, {15'd0, nmi_arm}, {15'd0, mnmi});
   endtask

   task automatic idle();
      cen = 1'b1; wr_en = 1'b0; wrh_en = 1'b0; cc_we = 1'b0; tfr = 1'b0; exg = 1'b0;
      idx_upd = 1'b0; wr_sel = 4'd0; wrh_sel = 4'd0; rslt = 16'd0; rslt_hi = 16'd0;
      cc_alu = 8'd0; postbyte = 8'd0; idx_sel = 2'd0; idx_delta = 2'd0;
   endtask

   // Called 1 time unit after a posedge with the strobes already driven.
   task automatic step(input string tag);
      #1;
      check({tag, ".opnd0_pre"}, opnd0, mread(rd_sel));
      model_step();
      @(posedge clk);
      #1;
      check_state(tag);
      idle();
   endtask

   // Asynchronous reset in the middle of a cycle with a write still pending.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      mreset();
      check_state(tag);
      idle();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      rd_sel = 4'd0;
      idle();
      mreset();
      #3;
      check_state("reset");
      rd_sel = 4'd1; #1 check("reset.opnd0_b", opnd0, 16'hFF00);
      rd_sel = 4'd8; #1 check("reset.opnd0_cc", opnd0, 16'hFF50);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // LMUL writeback
      wr_en = 1; wr_sel = 4'd3; rslt = 16'h5678;
      wrh_en = 1; wrh_sel = 4'd2; rslt_hi = 16'h1234;
      step("lmul");
      check("lmul.x", x, 16'h1234);
      check("lmul.y", y, 16'h5678);

      wr_en = 1; wr_sel = 4'd6; rslt = 16'h1234; step("ld_d");
      wr_en = 1; wr_sel = 4'd2; rslt = 16'hABCD; step("ld_x");
      exg = 1; postbyte = 8'h62; step("exg_dx");
      check("exg.d", d, 16'hABCD);
      check("exg.x", x, 16'h1234);
      tfr = 1; postbyte = 8'h07; step("tfr_adp");
      check("tfr.dp", {8'd0, dp}, 16'h00AB);

      // Precedence
      wr_en = 1; wr_sel = 4'd2; rslt = 16'h1111; idx_upd = 1; idx_sel = 2'd0; idx_delta = 2'd1;
      step("prec_x");
      check("prec.x", x, 16'h1111);
      wr_en = 1; wr_sel = 4'd0; rslt = 16'h0080; step("ld_a");
      cc_we = 1; cc_alu = 8'h0F; tfr = 1; postbyte = 8'h08; step("prec_cc");
      check("prec.cc", {8'd0, cc}, 16'h0080);

      // D partial overlap: B from rslt, A from rslt[15:8]
      wr_en = 1; wr_sel = 4'd6; rslt = 16'hABCD; wrh_en = 1; wrh_sel = 4'd1; rslt_hi = 16'h0077;
      step("dovl");
      check("dovl.d", d, 16'hABCD);

      // cen gating
      cen = 0; wr_en = 1; wr_sel = 4'd0; rslt = 16'h0055; idx_upd = 1; idx_sel = 2'd3;
      cc_we = 1; cc_alu = 8'hFF; exg = 1; postbyte = 8'h24;
      step("cen0");
      check("cen0.a", {8'd0, a}, 16'h00AB);
      check("cen0.nmi", {15'd0, nmi_arm}, 16'd0);

      // NMI arming and index wrap
      idx_upd = 1; idx_sel = 2'd3; idx_delta = 2'd3; step("s_dec");
      check("s_dec.s", s, 16'hFFFE);
      check("s_dec.nmi", {15'd0, nmi_arm}, 16'd1);
      idx_upd = 1; idx_sel = 2'd3; idx_delta = 2'd3; step("s_dec2");
      check("s_dec2.nmi", {15'd0, nmi_arm}, 16'd1);
      wr_en = 1; wr_sel = 4'd5; rslt = 16'h4242;
      do_reset("midrst");
      check("midrst.nmi", {15'd0, nmi_arm}, 16'd0);

      wr_en = 1; wr_sel = 4'd4; rslt = 16'h0001; step("ld_s");
      idx_upd = 1; idx_sel = 2'd3; idx_delta = 2'd3; step("s_wrap");
      check("s_wrap.s", s, 16'hFFFF);
      wr_en = 1; wr_sel = 4'd2; rslt = 16'hFFFF; step("ld_x2");
      idx_upd = 1; idx_sel = 2'd0; idx_delta = 2'd0; step("x_wrap");
      check("x_wrap.x", x, 16'h0000);

      // Invalid codes
      rd_sel = 4'd12; #1 check("inv.opnd0", opnd0, 16'hFFFF);
      wr_en = 1; wr_sel = 4'd12; rslt = 16'h9999; step("inv_wr");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         cen       = ($urandom_range(0, 7) != 0);
         rd_sel    = 4'($urandom_range(0, 15));
         wr_en     = ($urandom_range(0, 2) == 0);
         wr_sel    = 4'($urandom_range(0, 15));
         rslt      = 16'($urandom);
         wrh_en    = ($urandom_range(0, 3) == 0);
         wrh_sel   = 4'($urandom_range(0, 15));
         rslt_hi   = 16'($urandom);
         cc_we     = ($urandom_range(0, 2) == 0);
         cc_alu    = 8'($urandom);
         tfr       = ($urandom_range(0, 4) == 0);
         exg       = ($urandom_range(0, 4) == 0);
         postbyte  = 8'($urandom);
         idx_upd   = ($urandom_range(0, 3) == 0);
         idx_sel   = 2'($urandom_range(0, 3));
         idx_delta = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 63) == 0) do_reset("rnd_rst");
         else step("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
